hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline hazard sequencer for the 5-stage core; works beside the ID-stage and EX-stage forwarding units.
//  Issues stall, bubble and flush controls for three hazards: load-use, branch operands compared in ID, and multi-cycle mult/div occupancy.
//  Owns the mult/div busy FSM and a stall-cycle performance counter.
// PARAMETERS
//  MD_LATENCY  32  cycles a MULT/DIV occupies the HI/LO unit after issue from EX (>=2)
//  CNT_W       32  width of stall_cycles performance counter
// PORTS
//  clk              in   1   core clock; all state updates on rising edge
//  reset            in   1   synchronous, active-high reset
//  IF_ID_Rs         in   5   rs of instruction in ID
//  IF_ID_Rt         in   5   rt of instruction in ID
//  ID_UsesRs        in   1   ID instruction reads rs
//  ID_UsesRt        in   1   ID instruction reads rt
//  ID_Branch        in   1   ID instruction is a branch whose compare happens in ID
//  ID_MD_Use        in   1   ID instruction is MULT/DIV/MFHI/MFLO/MTHI/MTLO
//  ID_Taken         in   1   branch/jump in ID resolves taken (valid only when not stalled)
//  ID_EX_Rd         in   5   destination of instruction in EX
//  ID_EX_RegWrite   in   1   EX instruction writes a register
//  ID_EX_MemRead    in   1   EX instruction is a load
//  ID_EX_MD_Start   in   1   EX instruction is MULT/DIV (starts the unit this cycle)
//  EX_MEM_Rd        in   5   destination of instruction in MEM
//  EX_MEM_MemRead   in   1   MEM instruction is a load
//  PC_Write         out  1   1 = PC may advance
//  IF_ID_Write      out  1   1 = IF/ID register may load
//  ID_EX_Bubble     out  1   1 = load NOP controls into ID/EX
//  IF_ID_Flush      out  1   1 = squash instruction fetched behind a taken branch
//  md_busy          out  1   mult/div unit occupied (registered)
//  stall_cycles     out  CNT_W  count of cycles with stall asserted (registered)
// BEHAVIOUR
//  Match terms (combinational): mEX_s = ID_UsesRs && ID_EX_Rd!=0 && ID_EX_Rd==IF_ID_Rs; mEX_t, mMEM_s, mMEM_t analogous.
//  Hazard terms:
//   lu   = ID_EX_MemRead && (mEX_s||mEX_t)                    -- load-use, any instruction
//   brEX = ID_Branch && ID_EX_RegWrite && (mEX_s||mEX_t)       -- ALU result not yet in EX/MEM
//   brLd = ID_Branch && EX_MEM_MemRead && (mMEM_s||mMEM_t)     -- load data not until WB
//   md   = ID_MD_Use && md_busy_next_view, where view = md_busy && cnt!=1 (unit frees at end of cnt==1 cycle)
//  stall = lu | brEX | brLd | md.
//  stall=1: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0 (ID_Taken ignored while stalled).
//  stall=0: PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=ID_Taken.
//  Net effect: branch after ALU producer = 1 stall; branch after load = 2 stalls (brEX|lu, then brLd); plain load-use = 1 stall.
//  MD FSM (states IDLE, BUSY; counter cnt, $clog2(MD_LATENCY+1) bits):
//   IDLE: ID_EX_MD_Start -> BUSY, cnt<=MD_LATENCY.
//   BUSY: cnt<=cnt-1 each cycle; cnt==1 -> IDLE, cnt<=0.
//   BUSY and ID_EX_MD_Start together cannot occur (md stall prevents it); if seen, reload cnt<=MD_LATENCY, stay BUSY.
//   md_busy = (state==BUSY).
//  stall_cycles: +1 on every cycle with stall=1; wraps modulo 2^CNT_W; never saturates.
//  Reset (reset=1 at posedge): state<=IDLE, cnt<=0, stall_cycles<=0. While reset is high, outputs forced PC_Write=1,
//   IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0; md_busy=0 after first edge. Reset mid-BUSY aborts the operation.
//  Register $0 never creates a hazard. Combinational outputs: zero-latency from inputs and current state.
// STRUCTURE
//  Shared package core_pkg: REG_ZERO=5'd0, md_state_t {MD_IDLE, MD_BUSY}, default MD_LATENCY.
//  One sub-module: md_busy_tracker (FSM + cnt, outputs md_busy, md_free_next). Hazard terms and stall counter in top.
// TESTING
//  1 LW $2 in EX, ID ADD uses rs=$2 -> 1 cycle PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; stall_cycles 0->1.
//  2 LW $3 in EX, ID BEQ $3,$4 -> stall 2 cycles (lu, then brLd with EX_MEM_MemRead), then IF_ID_Flush=ID_Taken.
//  3 ADD $5 in EX, ID BNE $5,$0, ID_Taken=1 -> 1 stall with IF_ID_Flush=0, next cycle IF_ID_Flush=1, no stall.
//  4 MD_LATENCY=4, MULT start, MFLO in ID next cycle -> stalls while cnt=4,3,2; released at cnt==1; md_busy low after 4 cycles.
//  5 ID_EX_Rd=0 with MemRead, ID uses $0 -> no stall; ID_UsesRs=0 with match -> no stall.
//  6 reset asserted during BUSY (cnt=3) -> next cycle md_busy=0, stall_cycles=0, PC_Write=1; counter wraps from all-ones to 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: register constants, mult/div FSM state type, default latency.
package core_pkg;

  localparam int unsigned REG_W          = 5;
  localparam logic [4:0]  REG_ZERO       = 5'd0;
  localparam int unsigned MD_LATENCY_DEF = 32;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Tracks occupancy of the HI/LO mult/div unit after a MULT/DIV issues from EX.
module md_busy_tracker
  import core_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  output logic md_busy,
  output logic md_free_next
);

  localparam int unsigned CW = $clog2(MD_LATENCY + 1);

  md_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // State and countdown registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: load latency on start, count down while busy, free after the cnt==1 cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          state_d = MD_BUSY;
          cnt_d   = CW'(MD_LATENCY);
        end
      end
      MD_BUSY: begin
        if (md_start) begin
          // Should be blocked by the md stall; restart the operation if it happens anyway
          cnt_d = CW'(MD_LATENCY);
        end else if (cnt_q == CW'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign md_busy      = (state_q == MD_BUSY);
  // Unit is usable by the ID instruction once it reaches EX next cycle
  assign md_free_next = (state_q != MD_BUSY) || (cnt_q == CW'(1));

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard sequencer: load-use, ID-stage branch operand and mult/div occupancy stalls.
module hazard_stall_ctrl
  import core_pkg::*;
#(
  parameter int unsigned MD_LATENCY = MD_LATENCY_DEF,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] IF_ID_Rs,
  input  logic [REG_W-1:0] IF_ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_Branch,
  input  logic             ID_MD_Use,
  input  logic             ID_Taken,
  input  logic [REG_W-1:0] ID_EX_Rd,
  input  logic             ID_EX_RegWrite,
  input  logic             ID_EX_MemRead,
  input  logic             ID_EX_MD_Start,
  input  logic [REG_W-1:0] EX_MEM_Rd,
  input  logic             EX_MEM_MemRead,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  logic md_free_next;
  logic m_ex_s, m_ex_t, m_mem_s, m_mem_t;
  logic lu, br_ex, br_ld, md;
  logic stall;

  md_busy_tracker #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_busy_tracker (
    .clk          (clk),
    .reset        (reset),
    .md_start     (ID_EX_MD_Start),
    .md_busy      (md_busy),
    .md_free_next (md_free_next)
  );

  // Source-register matches against EX and MEM destinations; $0 never matches
  always_comb begin
    m_ex_s  = ID_UsesRs && (ID_EX_Rd  != REG_ZERO) && (ID_EX_Rd  == IF_ID_Rs);
    m_ex_t  = ID_UsesRt && (ID_EX_Rd  != REG_ZERO) && (ID_EX_Rd  == IF_ID_Rt);
    m_mem_s = ID_UsesRs && (EX_MEM_Rd != REG_ZERO) && (EX_MEM_Rd == IF_ID_Rs);
    m_mem_t = ID_UsesRt && (EX_MEM_Rd != REG_ZERO) && (EX_MEM_Rd == IF_ID_Rt);
  end

  // Hazard terms and pipeline controls; reset forces a free-running pipeline
  always_comb begin
    lu    = ID_EX_MemRead && (m_ex_s || m_ex_t);
    br_ex = ID_Branch && ID_EX_RegWrite && (m_ex_s || m_ex_t);
    br_ld = ID_Branch && EX_MEM_MemRead && (m_mem_s || m_mem_t);
    md    = ID_MD_Use && !md_free_next;
    stall = !reset && (lu || br_ex || br_ld || md);

    PC_Write     = !stall;
    IF_ID_Write  = !stall;
    ID_EX_Bubble = stall;
    IF_ID_Flush  = !reset && !stall && ID_Taken;
  end

  // Stall-cycle performance counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (stall) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
